sseg_scan_driver: RTL and testbench

SSEG_SCAN_DRIVER -- requirements
Module: sseg_scan_driver

---
 rtl/sseg_pkg.sv | 42 ++++
 rtl/sseg_scan_driver_if.sv | 31 +++
 rtl/sseg_scan_driver_bin2bcd_seq.sv | 79 +++++++
 rtl/sseg_scan_driver.sv | 91 +++++++++
 tb/tb_sseg_scan_driver.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/sseg_pkg.sv
// Shared constants, conversion FSM states and the seven-segment glyph table
// for the multiplexed display scanner.
package sseg_pkg;

    localparam int NUM_DIGITS = 8;
    localparam int DIGIT_W    = $clog2(NUM_DIGITS);
    localparam int NUM_BITS   = 32;
    localparam int BIT_CNT_W  = $clog2(NUM_BITS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } conv_state_e;

    // Active-low abcdefg glyphs; entry 0 sits in the least significant slot.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'b0111000,  // F
        7'b0110000,  // E
        7'b1000010,  // d
        7'b0110001,  // C
        7'b1100000,  // b
        7'b0001000,  // A
        7'b0000100,  // 9
        7'b0000000,  // 8
        7'b0001111,  // 7
        7'b0100000,  // 6
        7'b0100100,  // 5
        7'b1001100,  // 4
        7'b0000110,  // 3
        7'b0010010,  // 2
        7'b1001111,  // 1
        7'b0000001   // 0
    };

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] seg_encode(input logic [3:0] nibble);
        return SEG_TABLE[nibble];
    endfunction

endpackage

// File: rtl/sseg_scan_driver_if.sv
// Host-side bundle of the display driver: load request, value, mode and the
// busy / segment / anode outputs.
interface sseg_scan_driver_if;
    import sseg_pkg::*;

    logic                  load;
    logic                  dec;
    logic [NUM_BITS-1:0]   num;
    logic                  busy;
    logic [6:0]            segments;
    logic [NUM_DIGITS-1:0] anodes;

    modport master (
        output load,
        output dec,
        output num,
        input  busy,
        input  segments,
        input  anodes
    );

    modport slave (
        input  load,
        input  dec,
        input  num,
        output busy,
        output segments,
        output anodes
    );

endinterface

// File: rtl/sseg_scan_driver_bin2bcd_seq.sv
// Sequential double-dabble: one binary bit per cycle, MSB first. Only the low
// eight BCD digits are kept, so the result is the input modulo 10^8.
module bin2bcd_seq
    import sseg_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [NUM_BITS-1:0] bin,
    output logic                busy,
    output logic                done,
    output logic [NUM_BITS-1:0] bcd
);

    conv_state_e          state_q, state_d;
    logic [NUM_BITS-1:0]  shift_q, shift_d;
    logic [NUM_BITS-1:0]  bcd_q, bcd_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [NUM_BITS-1:0]  bcd_adj;

    // Dropping carries out of the top digit is what yields the mod 10^8 result.
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_adj
        assign bcd_adj[4*gi +: 4] = (bcd_q[4*gi +: 4] >= 4'd5) ?
                                    (bcd_q[4*gi +: 4] + 4'd3) :
                                    bcd_q[4*gi +: 4];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bcd_q     <= '0;
            bit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bcd_q     <= bcd_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bcd_d     = bcd_q;
        bit_cnt_d = bit_cnt_q;
        done      = 1'b0;
        busy      = (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    shift_d   = bin;
                    bcd_d     = '0;
                    bit_cnt_d = '0;
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                bcd_d     = {bcd_adj[NUM_BITS-2:0], shift_q[NUM_BITS-1]};
                shift_d   = {shift_q[NUM_BITS-2:0], 1'b0};
                bit_cnt_d = bit_cnt_q + 1'b1;
                if (bit_cnt_q == BIT_CNT_W'(NUM_BITS - 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bcd = bcd_q;

endmodule

// File: rtl/sseg_scan_driver.sv
// Eight-digit multiplexed seven-segment driver with hex pass-through and
// sequential binary-to-decimal conversion of the loaded value.
module sseg_scan_driver
    import sseg_pkg::*;
#(
    parameter int REFRESH_DIV = 1000
) (
    input  logic               clk,
    input  logic               rst_n,
    sseg_scan_driver_if.slave  bus
);

    localparam int                CNT_W   = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DIGIT_W-1:0]    digit_q, digit_d;
    logic [NUM_BITS-1:0]   display_q, display_d;
    logic [NUM_DIGITS-1:0] anodes_q, anodes_d;
    logic [6:0]            segments_q, segments_d;

    logic                  conv_busy;
    logic                  conv_done;
    logic [NUM_BITS-1:0]   conv_bcd;
    logic                  hex_load;
    logic                  dec_start;
    logic [3:0]            digit_nib [NUM_DIGITS];
    logic [3:0]            cur_nib;

    // Requests arriving while a conversion runs are dropped, not queued.
    assign hex_load  = bus.load & ~bus.dec & ~conv_busy;
    assign dec_start = bus.load &  bus.dec & ~conv_busy;

    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .rst_n (rst_n),
        .start (dec_start),
        .bin   (bus.num),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        assign digit_nib[gi] = display_q[4*gi +: 4];
        assign anodes_d[gi]  = (digit_q != DIGIT_W'(gi));
    end

    assign cur_nib = digit_nib[digit_q];

    always_comb begin
        cnt_d      = cnt_q + 1'b1;
        digit_d    = digit_q;
        display_d  = display_q;
        segments_d = seg_encode(cur_nib);

        if (cnt_q == CNT_MAX) begin
            cnt_d   = '0;
            digit_d = (digit_q == DIGIT_W'(NUM_DIGITS - 1)) ? '0 : (digit_q + 1'b1);
        end

        if (hex_load) begin
            display_d = bus.num;
        end else if (conv_done) begin
            display_d = conv_bcd;
        end
    end

    // Anodes and segments both follow the current digit index, so they move
    // together and the first digit gets its full refresh period after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            digit_q    <= '0;
            display_q  <= '0;
            anodes_q   <= '1;
            segments_q <= SEG_BLANK;
        end else begin
            cnt_q      <= cnt_d;
            digit_q    <= digit_d;
            display_q  <= display_d;
            anodes_q   <= anodes_d;
            segments_q <= segments_d;
        end
    end

    assign bus.busy     = conv_busy;
    assign bus.segments = segments_q;
    assign bus.anodes   = anodes_q;

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Directed scoreboard bench for sseg_scan_driver (REFRESH_DIV = 4).
module tb_sseg_scan_driver;

    typedef struct {
        int         cyc;
        logic [2:0] mask;   // [0] busy, [1] anodes, [2] segments
        logic       busy;
        logic [7:0] an;
        logic [6:0] seg;
        string      tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   rel = 0;
    int   n_vec = 0;
    int   n_err = 0;
    logic end_req = 1'b0;
    logic end_done = 1'b0;
    exp_t exp_q[$];

    logic [6:0] seg_tab [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    sseg_scan_driver_if bus ();

    sseg_scan_driver #(.REFRESH_DIV(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every expectation stamped for the current cycle.
    always @(negedge clk) begin
        exp_t e;
        logic ok;
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            n_vec++;
            ok = 1'b1;
            if (e.cyc != cyc) ok = 1'b0;
            if (e.mask[0] && bus.busy !== e.busy) ok = 1'b0;
            if (e.mask[1] && bus.anodes !== e.an) ok = 1'b0;
            if (e.mask[2] && bus.segments !== e.seg) ok = 1'b0;
            if (!ok) begin
                n_err++;
                $display("FAIL %s cyc=%0d (due %0d): busy=%b anodes=%h segments=%b, expected busy=%b anodes=%h segments=%b mask=%b",
                         e.tag, cyc, e.cyc, bus.busy, bus.anodes, bus.segments,
                         e.busy, e.an, e.seg, e.mask);
            end
        end
        if (end_req && !end_done) begin
            n_vec++;
            if (exp_q.size() != 0) begin
                n_err++;
                $display("FAIL scoreboard_drain: %0d expectations left, expected 0", exp_q.size());
            end
            end_done = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int c, input logic [2:0] m, input logic b,
                        input logic [7:0] a, input logic [6:0] s, input string t);
        exp_t e;
        e.cyc = c; e.mask = m; e.busy = b; e.an = a; e.seg = s; e.tag = t;
        exp_q.push_back(e);
    endtask

    task automatic reset_pulse(input int n, input string t);
        rst_n = 1'b0;
        for (int i = 0; i < n; i++) begin
            tick();
            push(cyc, 3'b111, 1'b0, 8'hFF, 7'b1111111, t);
        end
        rst_n = 1'b1;
        tick();
        rel = cyc;
        push(cyc, 3'b111, 1'b0, 8'hFE, 7'b0000001, {t, "_release"});
    endtask

    // Expected scan: digit j owns cycles rel+4j .. rel+4j+3, repeating every 32.
    task automatic check_scan(input logic [31:0] digs, input int n, input string t);
        int d;
        logic [7:0] an;
        logic [3:0] nib;
        for (int i = 1; i <= n; i++) begin
            d   = ((cyc + i - rel) / 4) % 8;
            an  = 8'h01 << d;
            nib = digs[4*d +: 4];
            push(cyc + i, 3'b111, 1'b0, ~an, seg_tab[nib], t);
        end
        repeat (n) tick();
    endtask

    task automatic do_load(input logic d, input logic [31:0] n, input int nchk, input string t);
        push(cyc, 3'b001, 1'b0, 8'h00, 7'h00, {t, "_pre"});
        bus.load = 1'b1;
        bus.dec  = d;
        bus.num  = n;
        for (int j = 0; j < nchk; j++) begin
            push(cyc + 1 + j, 3'b001, d && (j < 33), 8'h00, 7'h00, {t, "_busy"});
        end
        tick();
        bus.load = 1'b0;
        bus.dec  = 1'b0;
        bus.num  = 32'h0;
    endtask

    initial begin
        rst_n    = 1'b0;
        bus.load = 1'b0;
        bus.dec  = 1'b0;
        bus.num  = 32'h0;

        reset_pulse(3, "reset");
        check_scan(32'h0000_0000, 36, "scan_zero");

        do_load(1'b0, 32'h0123ABCD, 3, "hex");
        tick();
        check_scan(32'h0123_ABCD, 32, "hex_scan");

        do_load(1'b1, 32'd12345678, 34, "dec1");
        repeat (34) tick();
        check_scan(32'h1234_5678, 32, "dec1_scan");

        do_load(1'b1, 32'hFFFF_FFFF, 34, "dec_max");
        repeat (34) tick();
        check_scan(32'h9496_7295, 32, "dec_max_scan");

        do_load(1'b1, 32'd87654321, 34, "dec_ign");
        repeat (9) tick();
        bus.load = 1'b1;
        bus.dec  = 1'b0;
        bus.num  = 32'h0;
        tick();
        bus.load = 1'b0;
        repeat (24) tick();
        check_scan(32'h8765_4321, 32, "dec_ign_scan");

        do_load(1'b1, 32'd12345678, 20, "abort");
        repeat (19) tick();
        reset_pulse(1, "abort_rst");
        check_scan(32'h0000_0000, 48, "abort_scan");

        end_req = 1'b1;
        repeat (2) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
